// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - two-paddle position controller with accelerating human input and AI tracking
module paddle_ctrl #(
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_H    = 64,
  parameter int BASE_STEP   = 2,
  parameter int FAST_STEP   = 6,
  parameter int ACCEL_TICKS = 16,
  parameter int AI_STEP     = 3,
  parameter int AI_DEADBAND = 4,
  parameter int AI_PERIOD   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       freeze,
  input  logic       recenter,
  input  logic       right_mode,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic [9:0] ball_pos_y,
  output logic [9:0] left_y,
  output logic [9:0] right_y,
  output logic       left_fast,
  output logic       right_fast
);

  localparam int Y_MAX_I = SCREEN_H - PADDLE_H;
  localparam logic signed [10:0] Y_MAX  = 11'(Y_MAX_I);
  localparam logic [9:0]         CENTER = 10'(Y_MAX_I / 2);
  localparam int CW = $clog2(ACCEL_TICKS + 1);
  localparam int AW = (AI_PERIOD > 1) ? $clog2(AI_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCEL_TICKS - 1);
  localparam logic [AW-1:0] AI_LAST  = AW'(AI_PERIOD - 1);
  localparam logic signed [10:0] BASE_S = 11'(BASE_STEP);
  localparam logic signed [10:0] FAST_S = 11'(FAST_STEP);
  localparam logic signed [10:0] AI_S   = 11'(AI_STEP);
  localparam logic signed [10:0] DEAD_S = 11'(AI_DEADBAND);
  localparam logic signed [10:0] HALF_S = 11'(PADDLE_H / 2);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  // Add a signed delta to a position and clamp the result into 0..Y_MAX.
  function automatic logic [9:0] sat_pos(input logic [9:0] pos, input logic signed [10:0] delta);
    logic signed [10:0] sum;
    sum = $signed({1'b0, pos}) + delta;
    if (sum < 0)          return 10'd0;
    else if (sum > Y_MAX) return Y_MAX[9:0];
    else                  return sum[9:0];
  endfunction

  // One tick of the human channel: direction decode, IDLE/SLOW/FAST transitions and step size.
  // The hold counter only matters in SLOW; FAST keeps it untouched.
  function automatic void human_next(
    input  state_t             st,
    input  logic [CW-1:0]      cnt,
    input  dir_t               ldir,
    input  logic               up,
    input  logic               dn,
    output state_t             nst,
    output logic [CW-1:0]      ncnt,
    output dir_t               ndir,
    output logic signed [10:0] delta
  );
    dir_t d;
    logic signed [10:0] mag;
    d     = (up && !dn) ? DIR_UP : (dn && !up) ? DIR_DOWN : DIR_NONE;
    nst   = IDLE;
    ncnt  = '0;
    ndir  = d;
    mag   = '0;
    if (d != DIR_NONE) begin
      if (st == IDLE || d != ldir) begin
        nst  = SLOW;
        ncnt = CW'(1);
        mag  = BASE_S;
      end else if (st == SLOW && cnt != CNT_LAST) begin
        nst  = SLOW;
        ncnt = cnt + 1'b1;
        mag  = BASE_S;
      end else begin
        nst  = FAST;
        ncnt = cnt;
        mag  = FAST_S;
      end
    end
    delta = (d == DIR_UP) ? -mag : mag;
  endfunction

  state_t             l_state, l_state_n, r_state, r_state_n;
  logic [CW-1:0]      l_cnt, l_cnt_n, r_cnt, r_cnt_n;
  dir_t               l_dir, l_dir_n, r_dir, r_dir_n;
  logic signed [10:0] l_delta, r_delta;
  logic [AW-1:0]      ai_cnt, ai_cnt_n;
  logic [9:0]         ai_target;
  logic signed [10:0] ai_err, ai_abs, ai_mag, ai_delta;
  logic               mode_q;

  // Next state and step for both human channels.
  always_comb begin
    human_next(l_state, l_cnt, l_dir, p1_up, p1_down, l_state_n, l_cnt_n, l_dir_n, l_delta);
    human_next(r_state, r_cnt, r_dir, p2_up, p2_down, r_state_n, r_cnt_n, r_dir_n, r_delta);
  end

  // AI: step toward the ball-centred target on every AI_PERIOD-th tick, outside the deadband.
  always_comb begin
    ai_cnt_n  = ai_cnt + 1'b1;
    ai_delta  = '0;
    ai_mag    = '0;
    ai_target = sat_pos(ball_pos_y, -HALF_S);
    ai_err    = $signed({1'b0, ai_target}) - $signed({1'b0, right_y});
    ai_abs    = (ai_err < 0) ? -ai_err : ai_err;
    if (ai_cnt == AI_LAST) begin
      ai_cnt_n = '0;
      if (ai_abs > DEAD_S) begin
        ai_mag   = (ai_abs > AI_S) ? AI_S : ai_abs;
        ai_delta = (ai_err < 0) ? -ai_mag : ai_mag;
      end
    end
  end

  // State registers with priority reset > recenter > freeze > tick; right-mode change clears the right channel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      left_y  <= CENTER;
      right_y <= CENTER;
      l_state <= IDLE;
      r_state <= IDLE;
      l_cnt   <= '0;
      r_cnt   <= '0;
      l_dir   <= DIR_NONE;
      r_dir   <= DIR_NONE;
      ai_cnt  <= '0;
      mode_q  <= right_mode;
    end else begin
      mode_q <= right_mode;
      if (recenter) begin
        left_y  <= CENTER;
        right_y <= CENTER;
        l_state <= IDLE;
        r_state <= IDLE;
        l_cnt   <= '0;
        r_cnt   <= '0;
        ai_cnt  <= '0;
      end else if (freeze && tick) begin
        l_state <= IDLE;
        r_state <= IDLE;
        l_cnt   <= '0;
        r_cnt   <= '0;
        ai_cnt  <= '0;
      end else begin
        if (tick) begin
          l_state <= l_state_n;
          l_cnt   <= l_cnt_n;
          l_dir   <= l_dir_n;
          left_y  <= sat_pos(left_y, l_delta);
        end
        if (right_mode != mode_q) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          ai_cnt  <= '0;
        end else if (tick) begin
          if (right_mode) begin
            r_state <= r_state_n;
            r_cnt   <= r_cnt_n;
            r_dir   <= r_dir_n;
            right_y <= sat_pos(right_y, r_delta);
            ai_cnt  <= '0;
          end else begin
            ai_cnt  <= ai_cnt_n;
            right_y <= sat_pos(right_y, ai_delta);
          end
        end
      end
    end
  end

  assign left_fast  = (l_state == FAST);
  assign right_fast = (r_state == FAST) && right_mode;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - self-checking bench for paddle_ctrl
module tb_paddle_ctrl;

  localparam int Y_MAX  = 416;
  localparam int CENTER = 208;
  localparam int BASE   = 2;
  localparam int FASTS  = 6;
  localparam int ACCEL  = 16;
  localparam int AISTEP = 3;
  localparam int DEAD   = 4;
  localparam int PERIOD = 2;
  localparam int HALF   = 32;

  logic       clk = 1'b0;
  logic       reset, tick, freeze, recenter, right_mode;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic [9:0] ball_pos_y;
  logic [9:0] left_y, right_y;
  logic       left_fast, right_fast;

  int errors = 0;
  int checks = 0;

  int m_ly, m_ry, m_lrun, m_rrun, m_ldir, m_rdir, m_ai, m_pmode;

  paddle_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .freeze(freeze), .recenter(recenter),
    .right_mode(right_mode), .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up),
    .p2_down(p2_down), .ball_pos_y(ball_pos_y), .left_y(left_y), .right_y(right_y),
    .left_fast(left_fast), .right_fast(right_fast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : (v > Y_MAX) ? Y_MAX : v;
  endfunction

  // Human channel in terms of run length: how many consecutive ticks the same direction has been held.
  task automatic human(inout int y, inout int run, inout int ldir, input logic up, input logic dn);
    int d;
    d = (up && !dn) ? -1 : (dn && !up) ? 1 : 0;
    if (d == 0) run = 0;
    else if (d == ldir && run > 0) run = run + 1;
    else run = 1;
    ldir = d;
    if (run > 1000) run = 1000;
    y = clampi(y + d * ((run >= ACCEL) ? FASTS : BASE));
  endtask

  task automatic model_edge();
    int tgt, err, mag;
    if (!reset) begin
      m_ly = CENTER; m_ry = CENTER; m_lrun = 0; m_rrun = 0;
      m_ldir = 0; m_rdir = 0; m_ai = 0; m_pmode = int'(right_mode);
    end else begin
      logic chg;
      chg = (int'(right_mode) != m_pmode);
      m_pmode = int'(right_mode);
      if (recenter) begin
        m_ly = CENTER; m_ry = CENTER; m_lrun = 0; m_rrun = 0; m_ai = 0;
      end else if (freeze && tick) begin
        m_lrun = 0; m_rrun = 0; m_ai = 0;
      end else begin
        if (tick) human(m_ly, m_lrun, m_ldir, p1_up, p1_down);
        if (chg) begin
          m_rrun = 0; m_ai = 0;
        end else if (tick) begin
          if (right_mode) human(m_ry, m_rrun, m_rdir, p2_up, p2_down);
          else begin
            m_ai++;
            if (m_ai >= PERIOD) begin
              m_ai = 0;
              tgt = clampi(int'(ball_pos_y) - HALF);
              err = tgt - m_ry;
              mag = (err < 0) ? -err : err;
              if (mag > DEAD) begin
                if (mag > AISTEP) mag = AISTEP;
                m_ry = m_ry + ((err < 0) ? -mag : mag);
              end
            end
          end
        end
      end
    end
  endtask

  // One clock: model follows the edge, DUT compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_left_y", int'(left_y), m_ly);
    chk("model_right_y", int'(right_y), m_ry);
    chk("model_left_fast", int'(left_fast), int'(m_lrun >= ACCEL));
    chk("model_right_fast", int'(right_fast), int'(right_mode && m_rrun >= ACCEL));
  endtask

  task automatic do_reset();
    reset = 1'b0; tick = 1'b0; freeze = 1'b0; recenter = 1'b0;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    step();
    reset = 1'b1;
  endtask

  typedef struct {
    logic       rst, tk, frz, rc, md, u1, d1;
    logic [9:0] ball;
    int         ely, ery, elf, erf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd244, 208, 208, 0, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd244, 210, 208, 0, 0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd244, 212, 208, 0, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd244, 210, 208, 0, 0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0,   210, 205, 0, 0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   210, 205, 0, 0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   210, 205, 0, 0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0,   210, 205, 0, 0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0,   208, 208, 0, 0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0,   208, 208, 0, 0};

    reset = 1'b0; tick = 1'b0; freeze = 1'b0; recenter = 1'b0; right_mode = 1'b0;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0; ball_pos_y = 10'd244;

    for (int i = 0; i < 10; i++) begin
      reset = vecs[i].rst; tick = vecs[i].tk; freeze = vecs[i].frz; recenter = vecs[i].rc;
      right_mode = vecs[i].md; p1_up = vecs[i].u1; p1_down = vecs[i].d1;
      ball_pos_y = vecs[i].ball;
      step();
      chk($sformatf("vec%0d_left_y", i), int'(left_y), vecs[i].ely);
      chk($sformatf("vec%0d_right_y", i), int'(right_y), vecs[i].ery);
      chk($sformatf("vec%0d_left_fast", i), int'(left_fast), vecs[i].elf);
      chk($sformatf("vec%0d_right_fast", i), int'(right_fast), vecs[i].erf);
    end

    // Accelerate downward for 20 ticks.
    right_mode = 1'b0; ball_pos_y = 10'd244;
    do_reset();
    p1_down = 1'b1; tick = 1'b1;
    repeat (15) step();
    chk("accel_fast_at15", int'(left_fast), 0);
    chk("accel_y_at15", int'(left_y), 238);
    step();
    chk("accel_fast_at16", int'(left_fast), 1);
    chk("accel_y_at16", int'(left_y), 244);
    repeat (4) step();
    chk("accel_y_at20", int'(left_y), 268);

    // Saturate at the top, then both buttons drop FAST.
    do_reset();
    p1_up = 1'b1; tick = 1'b1;
    repeat (200) step();
    chk("top_left_y", int'(left_y), 0);
    chk("top_left_fast", int'(left_fast), 1);
    p1_down = 1'b1;
    step();
    chk("both_left_fast", int'(left_fast), 0);
    chk("both_left_y", int'(left_y), 0);

    // AI chase toward a low ball.
    ball_pos_y = 10'd400;
    do_reset();
    tick = 1'b1;
    repeat (10) step();
    chk("ai_right_y", int'(right_y), 223);
    chk("ai_right_fast", int'(right_fast), 0);

    // AI inside the deadband.
    ball_pos_y = 10'd244;
    do_reset();
    tick = 1'b1;
    repeat (10) step();
    chk("dead_right_y", int'(right_y), 208);

    // Freeze with tick from FAST.
    do_reset();
    p1_down = 1'b1; tick = 1'b1;
    repeat (17) step();
    chk("frz_pre_fast", int'(left_fast), 1);
    chk("frz_pre_y", int'(left_y), 250);
    freeze = 1'b1;
    step();
    chk("frz_y", int'(left_y), 250);
    chk("frz_fast", int'(left_fast), 0);
    freeze = 1'b0;
    step();
    chk("frz_after_y", int'(left_y), 252);

    // Both paddles to the limits, recenter without tick, then reset with recenter.
    right_mode = 1'b1;
    do_reset();
    p1_up = 1'b1; p2_down = 1'b1; tick = 1'b1;
    repeat (200) step();
    chk("lim_left_y", int'(left_y), 0);
    chk("lim_right_y", int'(right_y), Y_MAX);
    chk("lim_right_fast", int'(right_fast), 1);
    tick = 1'b0; recenter = 1'b1;
    step();
    chk("rc_left_y", int'(left_y), CENTER);
    chk("rc_right_y", int'(right_y), CENTER);
    chk("rc_right_fast", int'(right_fast), 0);
    recenter = 1'b0; tick = 1'b1;
    repeat (5) step();
    reset = 1'b0; recenter = 1'b1;
    step();
    chk("rstrc_left_y", int'(left_y), CENTER);
    chk("rstrc_right_y", int'(right_y), CENTER);
    chk("rstrc_left_fast", int'(left_fast), 0);
    recenter = 1'b0; reset = 1'b1;

    // Mode change while the second player is in FAST keeps the position.
    right_mode = 1'b1;
    do_reset();
    p2_down = 1'b1; tick = 1'b1;
    repeat (20) step();
    chk("mode_pre_right_y", int'(right_y), 268);
    chk("mode_pre_fast", int'(right_fast), 1);
    right_mode = 1'b0;
    step();
    chk("mode_chg_right_y", int'(right_y), 268);
    chk("mode_chg_fast", int'(right_fast), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset    = ($urandom_range(0, 299) != 0);
      recenter = ($urandom_range(0, 149) == 0);
      freeze   = ($urandom_range(0, 9) == 0);
      tick     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) right_mode = ~right_mode;
      if ($urandom_range(0, 39) == 0) {p1_up, p1_down} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) {p2_up, p2_down} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) ball_pos_y = 10'($urandom_range(0, 1023));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL provide parameter SCREEN_H, default 480, visible screen height in pixels.
REQ-002 SHALL provide parameter PADDLE_H, default 64, paddle height in pixels.
REQ-003 SHALL provide parameter BASE_STEP, default 2, human step per tick before acceleration.
REQ-004 SHALL provide parameter FAST_STEP, default 6, human step per tick after acceleration.
REQ-005 SHALL provide parameter ACCEL_TICKS, default 16, consecutive same-direction ticks to reach FAST (min 2).
REQ-006 SHALL provide parameter AI_STEP, default 3, maximum AI step per move.
REQ-007 SHALL provide parameter AI_DEADBAND, default 4, AI error tolerance in pixels.
REQ-008 SHALL provide parameter AI_PERIOD, default 2, ticks per AI move opportunity (min 1).
REQ-009 SHALL provide ports:
  clk  in  1  system clock, all logic on rising edge.
  reset  in  1  synchronous, active-low reset.
  tick  in  1  one-cycle frame-update strobe.
  freeze  in  1  hold paddles (serve or pause).
  recenter  in  1  one-cycle return-to-centre request.
  right_mode  in  1  0 = right paddle AI, 1 = right paddle second player.
  p1_up, p1_down  in  1 each  left paddle buttons, active-high.
  p2_up, p2_down  in  1 each  right paddle buttons, used only when right_mode=1.
  ball_pos_y  in  10  ball centre y.
  left_y  out  10  left paddle top y, registered.
  right_y  out  10  right paddle top y, registered.
  left_fast  out  1  left channel in FAST state.
  right_fast  out  1  right channel in FAST state (always 0 in AI mode).

Function
REQ-010 SHALL define Y_MAX = SCREEN_H-PADDLE_H (416) and CENTER = Y_MAX/2 (208); both positions SHALL stay within 0..Y_MAX at all times.
REQ-011 SHALL apply priority per cycle: reset > recenter > freeze > tick; with none active, all state holds.
REQ-012 SHALL update outputs on the clock edge at which tick is sampled high (visible the following cycle); no other latency.
REQ-013 SHALL derive human direction: up&~down = UP (-), down&~up = DOWN (+), both or neither = NONE.
REQ-014 SHALL run a per-channel human FSM with states IDLE, SLOW, FAST and a hold counter, evaluated only on unfrozen ticks.
REQ-015 IDLE: dir NONE -> stay, no move; dir UP/DOWN -> SLOW, counter=1, move BASE_STEP.
REQ-016 SLOW: same dir, counter==ACCEL_TICKS-1 -> FAST, move FAST_STEP; same dir otherwise -> counter+1, move BASE_STEP; reversed dir -> stay SLOW, counter=1, move BASE_STEP in new dir; NONE -> IDLE, counter=0.
REQ-017 FAST: same dir -> move FAST_STEP; reversed dir -> SLOW, counter=1, move BASE_STEP; NONE -> IDLE, counter=0.
REQ-018 SHALL compute moves at 11-bit signed width and saturate to 0 or Y_MAX; saturation SHALL NOT alter FSM transitions.
REQ-019 AI target SHALL be ball_pos_y-PADDLE_H/2 saturated to 0..Y_MAX.
REQ-020 AI SHALL keep a tick counter 0..AI_PERIOD-1, incrementing and wrapping on each unfrozen tick; a move opportunity occurs on the tick where the counter equals AI_PERIOD-1.
REQ-021 At a move opportunity, with err = target-right_y: |err| <= AI_DEADBAND -> no move; else move min(AI_STEP,|err|) toward target.
REQ-022 right_mode SHALL be sampled every cycle; a change SHALL force the right FSM to IDLE, counter=0, AI counter=0, and retain right_y.
REQ-023 freeze with tick SHALL hold positions, force both FSMs to IDLE, and clear all counters.
REQ-024 recenter SHALL, on any cycle irrespective of tick, set left_y=right_y=CENTER, FSMs to IDLE, and clear all counters.

Reset
REQ-025 When reset=0 at a clock edge: left_y=right_y=208, left_fast=right_fast=0, FSMs IDLE, all counters 0.
REQ-026 Reset SHALL take effect mid-motion with no residual state; first tick after release behaves as from IDLE.

Verification
REQ-027 Release reset, p1_down=1 for 20 ticks -> left_y=268 (15x2 + 5x6), left_fast=1 after tick 16.
REQ-028 p1_up=1 for 200 ticks from reset -> left_y=0 and held, left_fast=1; both buttons high next tick -> left_fast=0, left_y=0.
REQ-029 right_mode=0, ball_pos_y=400, 10 ticks from reset -> right_y=223 (5 moves of 3), right_fast=0.
REQ-030 right_mode=0, ball_pos_y=244 -> right_y stays 208 (err=4 within deadband).
REQ-031 Left in FAST, assert freeze with tick -> left_y unchanged, left_fast=0; next unfrozen tick with p1_down -> +2.
REQ-032 recenter pulse without tick while left_y=0, right_y=416 -> both 208 next cycle; reset=0 concurrent with recenter -> reset values.
